// File: rtl/hsid_pkg.sv
// Shared types and constants for the HSI identification min/max selector.
package hsid_pkg;

   localparam int HSID_DATA_WIDTH_ACC    = 32;
   localparam int HSID_HSP_LIBRARY_WIDTH = 4;

   localparam logic [HSID_DATA_WIDTH_ACC-1:0] HSID_DIST_MAX = {HSID_DATA_WIDTH_ACC{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } hsid_min_max_state_t;

endpackage

// File: rtl/hsid_min_max_sel.sv
// Tracks best (min) and worst (max) squared distance with reference index
// over one classification run; pulses done once every reference has arrived.
module hsid_min_max_sel
   import hsid_pkg::*;
#(
   parameter int DATA_WIDTH_ACC    = HSID_DATA_WIDTH_ACC,
   parameter int HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clean,
   input  logic                         start,
   input  logic [HSP_LIBRARY_WIDTH:0]   library_size,
   input  logic                         in_valid,
   input  logic [DATA_WIDTH_ACC-1:0]    in_value,
   input  logic                         in_last,
   input  logic [HSP_LIBRARY_WIDTH-1:0] in_ref,
   input  logic                         in_of,
   output logic                         busy,
   output logic                         done,
   output logic                         min_valid,
   output logic [DATA_WIDTH_ACC-1:0]    min_dist,
   output logic [HSP_LIBRARY_WIDTH-1:0] min_ref,
   output logic [DATA_WIDTH_ACC-1:0]    max_dist,
   output logic [HSP_LIBRARY_WIDTH-1:0] max_ref,
   output logic [HSP_LIBRARY_WIDTH:0]   of_count
);

   localparam logic [DATA_WIDTH_ACC-1:0]  DIST_ALL1 = {DATA_WIDTH_ACC{1'b1}};
   localparam logic [HSP_LIBRARY_WIDTH:0] CNT_ONE   = (HSP_LIBRARY_WIDTH+1)'(1);

   hsid_min_max_state_t state, state_nxt;

   logic [HSP_LIBRARY_WIDTH:0] size_q;
   logic [HSP_LIBRARY_WIDTH:0] cnt;
   logic [HSP_LIBRARY_WIDTH:0] cnt_nxt;
   logic                       res_beat;

   // Partial sums (in_last=0) and empty last beats never reach the selector.
   assign res_beat = in_last & (in_valid | in_of);
   assign cnt_nxt  = cnt + CNT_ONE;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (library_size == '0) ? DONE : RUN;
         RUN:     if (res_beat && cnt_nxt == size_q) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         size_q    <= '0;
         cnt       <= '0;
         min_valid <= 1'b0;
         min_dist  <= DIST_ALL1;
         min_ref   <= '0;
         max_dist  <= '0;
         max_ref   <= '0;
         of_count  <= '0;
      end else if (clean) begin
         state     <= IDLE;
         size_q    <= '0;
         cnt       <= '0;
         min_valid <= 1'b0;
         min_dist  <= DIST_ALL1;
         min_ref   <= '0;
         max_dist  <= '0;
         max_ref   <= '0;
         of_count  <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start) begin
            size_q    <= library_size;
            cnt       <= '0;
            min_valid <= 1'b0;
            min_dist  <= DIST_ALL1;
            min_ref   <= '0;
            max_dist  <= '0;
            max_ref   <= '0;
            of_count  <= '0;
         end else if (state == RUN && res_beat) begin
            cnt <= cnt_nxt;
            // Overflow takes precedence over a simultaneous valid.
            if (in_of) begin
               of_count <= of_count + CNT_ONE;
            end else begin
               if (in_value < min_dist) begin
                  min_dist <= in_value;
                  min_ref  <= in_ref;
               end
               // Strict compares keep the earliest reference on ties.
               if (!min_valid || in_value > max_dist) begin
                  max_dist <= in_value;
                  max_ref  <= in_ref;
               end
               min_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_hsid_min_max_sel.sv
// Scoreboarded directed bench for hsid_min_max_sel: expected results are queued
// when a run is launched and popped by a monitor on every done pulse.
module tb_hsid_min_max_sel;
   import hsid_pkg::*;

   localparam int DW = HSID_DATA_WIDTH_ACC;
   localparam int LW = HSID_HSP_LIBRARY_WIDTH;

   typedef struct {
      logic          mv;
      logic [DW-1:0] mn;
      logic [LW-1:0] mr;
      logic [DW-1:0] mx;
      logic [LW-1:0] xr;
      logic [LW:0]   of;
   } res_t;

   logic          clk = 1'b0;
   logic          rst, clean, start;
   logic [LW:0]   library_size;
   logic          in_valid, in_last, in_of;
   logic [DW-1:0] in_value;
   logic [LW-1:0] in_ref;
   logic          busy, done, min_valid;
   logic [DW-1:0] min_dist, max_dist;
   logic [LW-1:0] min_ref, max_ref;
   logic [LW:0]   of_count;

   res_t exp_q[$];
   int   nvec = 0;
   int   nerr = 0;

   hsid_min_max_sel dut (
      .clk(clk), .rst(rst), .clean(clean), .start(start),
      .library_size(library_size), .in_valid(in_valid), .in_value(in_value),
      .in_last(in_last), .in_ref(in_ref), .in_of(in_of),
      .busy(busy), .done(done), .min_valid(min_valid),
      .min_dist(min_dist), .min_ref(min_ref), .max_dist(max_dist),
      .max_ref(max_ref), .of_count(of_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_res(input string tag, input res_t e);
      chk({tag, ".min_valid"}, 64'(min_valid), 64'(e.mv));
      chk({tag, ".min_dist"},  64'(min_dist),  64'(e.mn));
      chk({tag, ".min_ref"},   64'(min_ref),   64'(e.mr));
      chk({tag, ".max_dist"},  64'(max_dist),  64'(e.mx));
      chk({tag, ".max_ref"},   64'(max_ref),   64'(e.xr));
      chk({tag, ".of_count"},  64'(of_count),  64'(e.of));
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_done: got done=1 required done=0");
         end else begin
            res_t e;
            e = exp_q.pop_front();
            chk("done.busy", 64'(busy), 64'(0));
            chk_res("done", e);
         end
      end
   end

   task automatic idle_in();
      start = 0; clean = 0; in_valid = 0; in_last = 0; in_of = 0;
      in_value = '0; in_ref = '0;
   endtask

   task automatic start_run(input int size, input res_t e);
      exp_q.push_back(e);
      library_size = (LW+1)'(size);
      start = 1;
      @(posedge clk); #1;
      start = 0;
   endtask

   task automatic beat(input int r, input int v, input logic last, input logic vld, input logic of);
      in_ref = LW'(r); in_value = DW'(v); in_last = last; in_valid = vld; in_of = of;
      @(posedge clk); #1;
      in_last = 0; in_valid = 0; in_of = 0; in_value = '0; in_ref = '0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         nvec++;
         nerr++;
         $display("FAIL %s.timeout: got %0d pending results required 0", tag, exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   res_t r1, r2, r3, r4, r5;

   initial begin
      r1 = '{mv:1'b1, mn:DW'(20), mr:LW'(1), mx:DW'(90), xr:LW'(2), of:'0};
      r2 = '{mv:1'b1, mn:DW'(3), mr:LW'(2), mx:DW'(7), xr:LW'(0), of:(LW+1)'(1)};
      r3 = '{mv:1'b0, mn:HSID_DIST_MAX, mr:'0, mx:'0, xr:'0, of:(LW+1)'(2)};
      r4 = '{mv:1'b0, mn:HSID_DIST_MAX, mr:'0, mx:'0, xr:'0, of:'0};
      r5 = '{mv:1'b1, mn:DW'(5), mr:LW'(3), mx:DW'(5), xr:LW'(3), of:'0};

      idle_in();
      library_size = '0;
      rst = 1;
      repeat (2) @(negedge clk);
      chk("rst.busy", 64'(busy), 64'(0));
      chk("rst.done", 64'(done), 64'(0));
      chk_res("rst", r4);
      @(posedge clk); #1;
      rst = 0;
      @(posedge clk); #1;

      // 1: plain run with a min tie (refs 1 and 3 both 20)
      start_run(4, r1);
      chk("s1.busy", 64'(busy), 64'(1));
      beat(0, 50, 1, 1, 0);
      beat(1, 20, 1, 1, 0);
      beat(2, 90, 1, 1, 0);
      beat(3, 20, 1, 1, 0);
      drain("s1");
      chk_res("s1.hold", r1);

      // 2: one overflowed reference
      start_run(3, r2);
      beat(0, 7, 1, 1, 0);
      beat(1, 999, 1, 0, 1);
      beat(2, 3, 1, 1, 0);
      drain("s2");

      // 3: all overflowed, one with in_valid also high
      start_run(2, r3);
      beat(0, 1, 1, 1, 1);
      beat(1, 2, 1, 0, 1);
      drain("s3");

      // 4: empty library goes straight to DONE
      start_run(0, r4);
      @(negedge clk);
      chk("s4.busy", 64'(busy), 64'(0));
      chk("s4.done", 64'(done), 64'(1));
      drain("s4");

      // 5: clean aborts mid-run without done
      library_size = (LW+1)'(3);
      start = 1;
      @(posedge clk); #1;
      start = 0;
      beat(0, 11, 1, 1, 0);
      beat(1, 12, 1, 1, 0);
      clean = 1;
      @(posedge clk); #1;
      clean = 0;
      @(negedge clk);
      chk("s5.busy", 64'(busy), 64'(0));
      chk("s5.done", 64'(done), 64'(0));
      chk_res("s5.clean", r4);
      repeat (4) @(posedge clk);
      #1;
      start_run(1, r5);
      beat(3, 5, 1, 1, 0);
      drain("s5b");

      // 6: partial beats, start in RUN, and a beat during DONE are ignored
      start_run(4, r1);
      beat(0, 50, 1, 1, 0);
      beat(5, 1, 0, 1, 0);
      beat(1, 20, 1, 1, 0);
      library_size = (LW+1)'(1);
      start = 1;
      @(posedge clk); #1;
      start = 0;
      beat(6, 1, 0, 1, 0);
      beat(2, 90, 1, 1, 0);
      beat(4, 0, 1, 0, 0);
      beat(3, 20, 1, 1, 0);
      beat(7, 0, 1, 1, 0);
      drain("s6");
      chk_res("s6.hold", r1);
      chk("s6.busy", 64'(busy), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running required finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/hsid_min_max_sel.md
Name: hsid_min_max_sel

Overview:
- Sits directly downstream of the squared-difference accumulator in the HSI identification datapath.
- Consumes one final squared-Euclidean distance per library reference and tracks the minimum distance (best match) and maximum distance (worst match) with their reference indices over one classification run.
- A run is started by the controller with the number of references expected. The block signals done once all of them have arrived.

Parameters:
- DATA_WIDTH_ACC, HSID_DATA_WIDTH_ACC: width of incoming accumulated distance.
- HSP_LIBRARY_WIDTH, HSID_HSP_LIBRARY_WIDTH: width of reference index.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- clean  in  1  synchronous flush to reset state
- start  in  1  one-cycle pulse, begins run
- library_size  in  HSP_LIBRARY_WIDTH+1  number of references in run, sampled on start
- in_valid  in  1  distance valid and not overflowed
- in_value  in  DATA_WIDTH_ACC  accumulated distance
- in_last  in  1  beat is final sum for a reference
- in_ref  in  HSP_LIBRARY_WIDTH  reference index of beat
- in_of  in  1  accumulation overflowed for this reference
- busy  out  1  run in progress
- done  out  1  one-cycle pulse, results final
- min_valid  out  1  at least one non-overflowed reference seen
- min_dist  out  DATA_WIDTH_ACC  smallest distance
- min_ref  out  HSP_LIBRARY_WIDTH  index of smallest
- max_dist  out  DATA_WIDTH_ACC  largest distance
- max_ref  out  HSP_LIBRARY_WIDTH  index of largest
- of_count  out  HSP_LIBRARY_WIDTH+1  references discarded due to overflow

Behaviour:
- Reset (rst high, asynchronous) and clean (synchronous, highest priority over all other inputs) have the same effect:
  - state=IDLE.
  - All outputs 0, except min_dist, which resets to all-ones.
  - Internal received counter = 0.
- Result beat: in_last=1 && (in_valid || in_of).
  - Non-last beats are partial sums and are ignored.
  - in_last=1 with in_valid=0 and in_of=0 is ignored.
- FSM states, in hsid_min_max_state_t: IDLE, RUN, DONE.
  - IDLE:
    - On start: latch library_size; min_dist=all-ones; max_dist=0; min_ref=max_ref=0; min_valid=0; of_count=0; counter=0.
    - Go to RUN if library_size!=0, else go to DONE.
    - Result beats in IDLE are dropped.
  - RUN: busy=1.
    - On a result beat, counter increments.
    - If in_of=1: of_count increments; min/max are untouched (in_of wins even if in_valid=1).
    - Else: if in_value < min_dist (strict), update min_dist/min_ref. If in_value > max_dist, or min_valid was 0, update max_dist/max_ref. min_valid is set to 1.
    - A beat that makes counter == latched size goes to DONE at the same edge, with that beat included in the results.
    - start in RUN is ignored.
  - DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
    - Result beats and start in DONE are ignored.
- Latency: final beat sampled at edge k → results and done=1 visible in cycle k..k+1.
- Results (min_*, max_*, min_valid, of_count) hold their values after DONE until the next start, clean or rst.
- Ties: the earliest-arriving reference is kept for both min and max.
- All references overflowed: done still pulses, min_valid=0, min_dist=all-ones, max_dist=0.
- Duplicate in_ref values are not checked; every result beat counts.
- Comparisons are unsigned at full DATA_WIDTH_ACC; no arithmetic widening is needed.
- Counter and of_count are HSP_LIBRARY_WIDTH+1 bits, so library_size=2^HSP_LIBRARY_WIDTH is legal without wrap.
- rst or clean mid-RUN aborts the run; no done pulse is issued.

Decomposition:
- In hsid_pkg:
  - hsid_min_max_state_t enum (IDLE, RUN, DONE).
  - HSID_DIST_MAX constant (all-ones at HSID_DATA_WIDTH_ACC).
- No sub-module. The two comparators and the FSM live in one always_ff plus one always_comb next-state block.

Test Plan:
1. library_size=4; beats (ref,value)=(0,50),(1,20),(2,90),(3,20), all valid and last → done one cycle after the 4th beat; min_dist=20, min_ref=1, max_dist=90, max_ref=2, of_count=0, min_valid=1.
2. library_size=3; ref 1 arrives with in_of=1, in_valid=0, refs 0 and 2 have values 7 and 3 → min_ref=2, min=3, max_ref=0, max=7, of_count=1.
3. library_size=2; both beats arrive with in_of=1 → done pulses, min_valid=0, min_dist=all-ones, max_dist=0, of_count=2.
4. library_size=0 start → done in the following cycle, busy never set, min_valid=0.
5. library_size=3; 2 beats, then clean → state IDLE, outputs reset, no done. A later start with size 1 and value 5 → min=max=5.
6. Interleaved in_last=0 partial beats (value 1) and a start pulse during RUN → ignored, results match scenario 1; beat presented in the DONE cycle → not counted.
